// File: rtl/dcache_stb_pkg.sv
// Shared types and default sizing for the store-buffer write responder.
package dcache_stb_pkg;

  localparam int ADDR_W_DEF         = 32;
  localparam int DATA_W_DEF         = 32;
  localparam int IDX_W_DEF          = 7;
  localparam int TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MEM_WR = 2'd2,
    ACK    = 2'd3
  } stb_state_e;

endpackage

// File: rtl/dcache_stb_responder_if.sv
// Store-buffer, tag/data array and write-through memory signals of the responder.
interface dcache_stb_responder_if #(
  parameter int ADDR_W = dcache_stb_pkg::ADDR_W_DEF,
  parameter int DATA_W = dcache_stb_pkg::DATA_W_DEF,
  parameter int IDX_W  = dcache_stb_pkg::IDX_W_DEF
);
  localparam int SEL_W = DATA_W / 8;

  logic              stb2dcache_req;
  logic              stb2dcache_w_en;
  logic [ADDR_W-1:0] stb2dcache_addr;
  logic [DATA_W-1:0] stb2dcache_wdata;
  logic [SEL_W-1:0]  stb2dcache_sel;
  logic              dcache2stb_ack;
  logic              dcache_busy_i;
  logic              tag_rd_en_o;
  logic [IDX_W-1:0]  tag_idx_o;
  logic              tag_hit_i;
  logic              data_wr_en_o;
  logic [IDX_W-1:0]  data_wr_idx_o;
  logic [DATA_W-1:0] data_wr_data_o;
  logic [SEL_W-1:0]  data_wr_sel_o;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [SEL_W-1:0]  mem_sel_o;
  logic              mem_ack_i;
  logic              stb_err_o;

  // Responder side.
  modport slave (
    input  stb2dcache_req, stb2dcache_w_en, stb2dcache_addr, stb2dcache_wdata,
           stb2dcache_sel, dcache_busy_i, tag_hit_i, mem_ack_i,
    output dcache2stb_ack, tag_rd_en_o, tag_idx_o, data_wr_en_o, data_wr_idx_o,
           data_wr_data_o, data_wr_sel_o, mem_req_o, mem_addr_o, mem_wdata_o,
           mem_sel_o, stb_err_o
  );

  // Environment side: store buffer, cache arrays and memory.
  modport master (
    output stb2dcache_req, stb2dcache_w_en, stb2dcache_addr, stb2dcache_wdata,
           stb2dcache_sel, dcache_busy_i, tag_hit_i, mem_ack_i,
    input  dcache2stb_ack, tag_rd_en_o, tag_idx_o, data_wr_en_o, data_wr_idx_o,
           data_wr_data_o, data_wr_sel_o, mem_req_o, mem_addr_o, mem_wdata_o,
           mem_sel_o, stb_err_o
  );
endinterface

// File: rtl/dcache_stb_responder.sv
// Write-through, write-no-allocate store responder between store buffer and D-cache.
// Build option: define DCACHE_STB_TIMEOUT_EN to enable the memory-write watchdog.
module dcache_stb_responder
  import dcache_stb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int IDX_W          = IDX_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  dcache_stb_responder_if.slave  bus
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef DCACHE_STB_TIMEOUT_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  stb_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [SEL_W-1:0]  sel_q;
  logic              mem_req_q;
  logic              ack_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              capture;

  // Tag lookup and array write must land in the capture/lookup cycles themselves,
  // so they are decoded from state and live inputs rather than registered.
  assign capture = (state_q == IDLE) && !rst && bus.stb2dcache_req &&
                   bus.stb2dcache_w_en && !bus.dcache_busy_i;

  assign bus.tag_rd_en_o    = capture;
  assign bus.tag_idx_o      = capture ? bus.stb2dcache_addr[IDX_W+1:2] : '0;
  assign bus.data_wr_en_o   = (state_q == LOOKUP) && !rst && (sel_q != '0) && bus.tag_hit_i;
  assign bus.data_wr_idx_o  = addr_q[IDX_W+1:2];
  assign bus.data_wr_data_o = data_q;
  assign bus.data_wr_sel_o  = sel_q;
  assign bus.mem_req_o      = mem_req_q;
  assign bus.mem_addr_o     = addr_q;
  assign bus.mem_wdata_o    = data_q;
  assign bus.mem_sel_o      = sel_q;
  assign bus.dcache2stb_ack = ack_q;
  assign bus.stb_err_o      = WDOG_EN ? err_q : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      sel_q     <= '0;
      mem_req_q <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (capture) begin
            addr_q  <= bus.stb2dcache_addr;
            data_q  <= bus.stb2dcache_wdata;
            sel_q   <= bus.stb2dcache_sel;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (sel_q == '0) begin
            ack_q   <= 1'b1;
            state_q <= ACK;
          end else begin
            mem_req_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= MEM_WR;
          end
        end
        MEM_WR: begin
          // A memory ack in the final watchdog cycle still wins over the timeout.
          if (bus.mem_ack_i) begin
            mem_req_q <= 1'b0;
            ack_q     <= 1'b1;
            state_q   <= ACK;
          end else if (WDOG_EN && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            mem_req_q <= 1'b0;
            ack_q     <= 1'b1;
            err_q     <= 1'b1;
            state_q   <= ACK;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_stb_responder.sv
// Directed bench for dcache_stb_responder: hit/miss timing, back-to-back, busy, reset, watchdog.
module tb_dcache_stb_responder;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   ack_cnt;

  dcache_stb_responder_if bus ();

  dcache_stb_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.dcache2stb_ack === 1'b1) ack_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // One complete store starting in an IDLE cycle; returns one cycle after the ACK cycle.
  // nwait = MEM_WR cycle in which mem_ack_i is given; hold keeps req high through ACK;
  // mid drops req, scrambles the store inputs and raises busy while in flight.
  task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit hit, input int nwait,
                          input bit hold, input bit mid);
    bit exp_wr;
    bus.stb2dcache_req   = 1'b1;
    bus.stb2dcache_w_en  = 1'b1;
    bus.stb2dcache_addr  = a;
    bus.stb2dcache_wdata = d;
    bus.stb2dcache_sel   = s;
    bus.dcache_busy_i    = 1'b0;
    #1;
    chk({tag, ".tag_rd_en"}, bus.tag_rd_en_o, 1);
    chk({tag, ".tag_idx"}, bus.tag_idx_o, a[8:2]);
    next();
    bus.tag_hit_i = hit;
    if (mid) begin
      bus.stb2dcache_req   = 1'b0;
      bus.stb2dcache_addr  = ~a;
      bus.stb2dcache_wdata = ~d;
      bus.stb2dcache_sel   = ~s;
      bus.dcache_busy_i    = 1'b1;
    end
    #1;
    exp_wr = hit && (s != 4'h0);
    chk({tag, ".lk_tag_rd_en"}, bus.tag_rd_en_o, 0);
    chk({tag, ".lk_mem_req"}, bus.mem_req_o, 0);
    chk({tag, ".data_wr_en"}, bus.data_wr_en_o, exp_wr);
    if (exp_wr) begin
      chk({tag, ".data_wr_idx"}, bus.data_wr_idx_o, a[8:2]);
      chk({tag, ".data_wr_data"}, bus.data_wr_data_o, d);
      chk({tag, ".data_wr_sel"}, bus.data_wr_sel_o, s);
    end
    next();
    bus.tag_hit_i = 1'b0;
    if (s != 4'h0) begin
      for (int k = 1; k <= nwait; k++) begin
        bus.mem_ack_i = (k == nwait);
        #1;
        chk({tag, ".mem_req"}, bus.mem_req_o, 1);
        chk({tag, ".mw_ack"}, bus.dcache2stb_ack, 0);
        chk({tag, ".mw_data_wr_en"}, bus.data_wr_en_o, 0);
        if (k == 1 || k == nwait) begin
          chk({tag, ".mem_addr"}, bus.mem_addr_o, a);
          chk({tag, ".mem_wdata"}, bus.mem_wdata_o, d);
          chk({tag, ".mem_sel"}, bus.mem_sel_o, s);
        end
        next();
      end
      bus.mem_ack_i = 1'b0;
    end
    if (!hold) bus.stb2dcache_req = 1'b0;
    #1;
    chk({tag, ".ack"}, bus.dcache2stb_ack, 1);
    chk({tag, ".ack_mem_req"}, bus.mem_req_o, 0);
    chk({tag, ".ack_err"}, bus.stb_err_o, 0);
    chk({tag, ".ack_no_recapture"}, bus.tag_rd_en_o, 0);
    bus.dcache_busy_i = 1'b0;
    next();
    chk({tag, ".ack_one_cycle"}, bus.dcache2stb_ack, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0;
    int n;
    n_vec = 0;
    n_err = 0;
    ack_cnt = 0;
    rst = 1'b1;
    bus.stb2dcache_req   = 1'b0;
    bus.stb2dcache_w_en  = 1'b0;
    bus.stb2dcache_addr  = '0;
    bus.stb2dcache_wdata = '0;
    bus.stb2dcache_sel   = '0;
    bus.dcache_busy_i    = 1'b0;
    bus.tag_hit_i        = 1'b0;
    bus.mem_ack_i        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ack", bus.dcache2stb_ack, 0);
    chk("rst.mem_req", bus.mem_req_o, 0);
    chk("rst.tag_rd_en", bus.tag_rd_en_o, 0);
    chk("rst.data_wr_en", bus.data_wr_en_o, 0);
    chk("rst.err", bus.stb_err_o, 0);
    chk("rst.mem_addr", bus.mem_addr_o, 0);
    rst = 1'b0;
    next();

    // Hit with immediate memory ack, then a miss with a 5-cycle memory wait.
    do_store("hit", 32'h0000_0104, 32'hDEAD_BEEF, 4'hF, 1'b1, 1, 1'b0, 1'b0);
    do_store("miss", 32'h0000_0104, 32'hDEAD_BEEF, 4'hF, 1'b0, 5, 1'b0, 1'b0);

    // Back-to-back with req held high across both.
    a0 = ack_cnt;
    do_store("b2b0", 32'h0000_0208, 32'h1122_3344, 4'h3, 1'b1, 2, 1'b1, 1'b0);
    do_store("b2b1", 32'h0000_020C, 32'h5566_7788, 4'hC, 1'b0, 1, 1'b0, 1'b0);
    chk("b2b.acks", ack_cnt - a0, 2);

    // Busy and disabled writes block capture.
    bus.stb2dcache_req  = 1'b1;
    bus.stb2dcache_w_en = 1'b1;
    bus.stb2dcache_sel  = 4'hF;
    bus.dcache_busy_i   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("busy.tag_rd_en%0d", i), bus.tag_rd_en_o, 0);
      next();
    end
    bus.dcache_busy_i   = 1'b0;
    bus.stb2dcache_w_en = 1'b0;
    #1;
    chk("wen0.tag_rd_en", bus.tag_rd_en_o, 0);
    next();
    chk("busy.no_ack", bus.dcache2stb_ack, 0);
    do_store("zmask", 32'h0000_0010, 32'hAAAA_5555, 4'h0, 1'b1, 1, 1'b0, 1'b0);

    // Inputs change and busy rises mid-flight; registered store still completes.
    do_store("mid", 32'h0000_03FC, 32'hCAFE_F00D, 4'h5, 1'b1, 3, 1'b0, 1'b1);

    // Asynchronous reset while in MEM_WR.
    bus.stb2dcache_req   = 1'b1;
    bus.stb2dcache_w_en  = 1'b1;
    bus.stb2dcache_addr  = 32'h0000_0500;
    bus.stb2dcache_wdata = 32'h0BAD_F00D;
    bus.stb2dcache_sel   = 4'hF;
    next();
    bus.stb2dcache_req = 1'b0;
    next();
    #1;
    chk("rstmw.mem_req_before", bus.mem_req_o, 1);
    a0 = ack_cnt;
    #2;
    rst = 1'b1;
    #1;
    chk("rstmw.mem_req", bus.mem_req_o, 0);
    chk("rstmw.ack", bus.dcache2stb_ack, 0);
    next();
    rst = 1'b0;
    next();
    next();
    chk("rstmw.mem_req_after", bus.mem_req_o, 0);
    chk("rstmw.no_ack", ack_cnt - a0, 0);
    do_store("post_rst", 32'h0000_0500, 32'h0000_0001, 4'h0, 1'b0, 1, 1'b0, 1'b0);

    // Memory never answers.
    bus.stb2dcache_req   = 1'b1;
    bus.stb2dcache_w_en  = 1'b1;
    bus.stb2dcache_addr  = 32'h0000_0600;
    bus.stb2dcache_wdata = 32'h1357_9BDF;
    bus.stb2dcache_sel   = 4'hF;
    next();
    bus.stb2dcache_req = 1'b0;
    next();
    n = 0;
`ifdef DCACHE_STB_TIMEOUT_EN
    for (int i = 0; i < 200; i++) begin
      #1;
      if (bus.dcache2stb_ack === 1'b1) break;
      if (bus.mem_req_o === 1'b1) n++;
      next();
    end
    chk("to.mem_wr_cycles", n, 64);
    chk("to.ack", bus.dcache2stb_ack, 1);
    chk("to.err", bus.stb_err_o, 1);
    chk("to.mem_req", bus.mem_req_o, 0);
    next();
    chk("to.ack_clear", bus.dcache2stb_ack, 0);
    chk("to.err_clear", bus.stb_err_o, 0);
    do_store("prio", 32'h0000_0040, 32'h2468_ACE0, 4'hF, 1'b0, 64, 1'b0, 1'b0);
`else
    a0 = ack_cnt;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus.mem_req_o === 1'b1 && bus.dcache2stb_ack !== 1'b1) n++;
      next();
    end
    chk("nto.mem_wr_cycles", n, 100);
    chk("nto.no_ack", ack_cnt - a0, 0);
    bus.mem_ack_i = 1'b1;
    next();
    bus.mem_ack_i = 1'b0;
    #1;
    chk("nto.ack", bus.dcache2stb_ack, 1);
    chk("nto.err", bus.stb_err_o, 0);
    chk("nto.mem_req", bus.mem_req_o, 0);
    next();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
